// File: rtl/word_packer.sv
// word_packer: frames a back-to-back byte stream of length-prefixed packets
// into 32-bit big-endian words with a last flag on a valid/ready interface.
// Packets whose length field is outside [MIN_LEN, MAX_LEN] are swallowed
// whole and flagged with a one-cycle lenError pulse.
// Optional: define WORD_PACKER_STATS_EN to add pktCount/dropCount outputs.
module word_packer #(
    parameter int MIN_LEN = 9,
    parameter int MAX_LEN = 45
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [7:0]  byteIn,
    input  logic        byteIn_val,
    output logic        byteIn_ready,
    output logic [31:0] dataOut,
    output logic        dataOut_val,
    input  logic        dataOut_ready,
    output logic        dataOut_last,
    output logic        lenError
`ifdef WORD_PACKER_STATS_EN
    ,
    output logic [15:0] pktCount,
    output logic [15:0] dropCount
`endif
);

    typedef enum logic [1:0] {LEN_HI, LEN_LO, PASS, DROP} state_t;

    localparam logic [15:0] MinL = 16'(MIN_LEN);
    localparam logic [15:0] MaxL = 16'(MAX_LEN);

    state_t      state, nextState;
    logic [31:0] acc;
    logic [1:0]  bytePos;
    logic [15:0] remaining;
    logic [31:0] packedWord;
    logic [15:0] lenVal;
    logic        lenOk;
    logic        accept;
    logic        wordDone;

    assign accept   = byteIn_val && byteIn_ready;
    assign lenVal   = {acc[31:24], byteIn};
    assign lenOk    = (lenVal >= MinL) && (lenVal <= MaxL);
    assign wordDone = (bytePos == 2'd3) || (remaining == 16'd1);

    // Merge the incoming byte into the accumulator; lanes past bytePos read as zero
    always_comb begin
        packedWord = '0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) < bytePos)
                packedWord[31-8*i -: 8] = acc[31-8*i -: 8];
            else if (2'(i) == bytePos)
                packedWord[31-8*i -: 8] = byteIn;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_b) state <= LEN_HI;
        else          state <= nextState;
    end

    // Next-state logic; only advances on an accepted byte
    always_comb begin
        nextState = state;
        if (accept) begin
            case (state)
                LEN_HI: nextState = LEN_LO;
                LEN_LO: begin
                    if (lenOk)               nextState = PASS;
                    else if (lenVal > 16'd2) nextState = DROP;
                    else                     nextState = LEN_HI;
                end
                PASS:   if (remaining == 16'd1) nextState = LEN_HI;
                DROP:   if (remaining == 16'd1) nextState = LEN_HI;
                default: nextState = LEN_HI;
            endcase
        end
    end

    // Input ready: DROP never stalls, otherwise wait for room in the output register
    always_comb begin
        byteIn_ready = 1'b1;
        if (state != DROP)
            byteIn_ready = !dataOut_val || dataOut_ready;
    end

    // Datapath: accumulator, counters and the single-entry output register
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            acc          <= '0;
            bytePos      <= '0;
            remaining    <= '0;
            dataOut      <= '0;
            dataOut_val  <= 1'b0;
            dataOut_last <= 1'b0;
            lenError     <= 1'b0;
        end else begin
            lenError <= 1'b0;
            if (dataOut_val && dataOut_ready)
                dataOut_val <= 1'b0;
            if (accept) begin
                case (state)
                    LEN_HI: acc[31:24] <= byteIn;
                    LEN_LO: begin
                        acc[23:16] <= byteIn;
                        if (lenOk) begin
                            remaining <= lenVal - 16'd2;
                            bytePos   <= 2'd2;
                        end else begin
                            lenError <= 1'b1;
                            if (lenVal > 16'd2)
                                remaining <= lenVal - 16'd2;
                        end
                    end
                    PASS: begin
                        remaining <= remaining - 16'd1;
                        if (wordDone) begin
                            dataOut      <= packedWord;
                            dataOut_val  <= 1'b1;
                            dataOut_last <= (remaining == 16'd1);
                            bytePos      <= 2'd0;
                            acc          <= '0;
                        end else begin
                            acc     <= packedWord;
                            bytePos <= bytePos + 2'd1;
                        end
                    end
                    DROP: remaining <= remaining - 16'd1;
                    default: ;
                endcase
            end
        end
    end

`ifdef WORD_PACKER_STATS_EN
    // Saturating packet / drop counters
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            pktCount  <= '0;
            dropCount <= '0;
        end else begin
            if (dataOut_val && dataOut_ready && dataOut_last && pktCount != 16'hFFFF)
                pktCount <= pktCount + 16'd1;
            if (accept && state == LEN_LO && !lenOk && dropCount != 16'hFFFF)
                dropCount <= dropCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Upstream neighbour of the sequence parser.
- Takes a raw byte stream of back-to-back packets and frames each packet into 32-bit big-endian words with a last flag, on a valid/ready interface.
- Packet format on the byte stream:
  - 16-bit total length L, counted in bytes and including the 8-byte header.
  - 16-bit stream id.
  - 32-bit sequence number.
  - L-8 payload bytes.
- Packets whose length is out of range are discarded whole, and a one-cycle error pulse is raised.

Parameters:
- MIN_LEN, 9, smallest legal L (8-byte header plus 1 payload byte).
- MAX_LEN, 45, largest legal L (8-byte header plus 37 payload bytes, i.e. the 296-bit parser record).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_b  in  1  synchronous active-low reset.
- byteIn  in  8  input byte.
- byteIn_val  in  1  byteIn valid.
- byteIn_ready  out  1  byte accepted when byteIn_val && byteIn_ready.
- dataOut  out  32  packed word; first byte of the word in [31:24].
- dataOut_val  out  1  dataOut valid.
- dataOut_ready  in  1  downstream accepts the word.
- dataOut_last  out  1  final word of the packet; qualified by dataOut_val.
- lenError  out  1  one-cycle pulse when a bad length field is detected.

Behaviour:
- Reset (reset_b low at posedge):
  - All outputs 0, except byteIn_ready, which is 1 after reset (output register empty).
  - State LEN_HI; accumulator, byte position and remaining-byte counter cleared.
  - Any partially assembled or held word is discarded. This applies equally when reset lands mid-packet.
- States:
  - LEN_HI: accepted byte goes to acc[31:24] → LEN_LO.
  - LEN_LO: accepted byte goes to acc[23:16]; L = {acc[31:24], byte}.
    - MIN_LEN <= L <= MAX_LEN: remaining = L-2, bytePos = 2 → PASS.
    - Otherwise: lenError = 1 for the next cycle only. If L > 2: remaining = L-2 → DROP. If L <= 2: → LEN_HI.
  - PASS: byte written at lane bytePos (0 → [31:24] … 3 → [7:0]); remaining decrements.
    - A word completes when bytePos == 3 or remaining == 1.
    - On completion, acc loads the output register with all unfilled lanes zeroed; dataOut_last = (remaining == 1); bytePos resets to 0.
    - When remaining reaches 0 → LEN_HI.
  - DROP: bytes consumed and discarded; remaining decrements; on the last byte → LEN_HI. No word is ever produced for a dropped packet.
- Handshake:
  - Output register holds one word. dataOut_val is set on completion and cleared when dataOut_val && dataOut_ready, unless a new word completes in the same cycle, in which case the register reloads and val stays 1.
  - dataOut and dataOut_last are stable while dataOut_val && !dataOut_ready.
  - byteIn_ready = !dataOut_val || dataOut_ready in LEN_HI/LEN_LO/PASS, and 1 in DROP.
  - No byte is accepted while byteIn_val is low; state does not advance.
- Latency and throughput: a word is visible on dataOut the cycle after its final byte is accepted. Sustained throughput is 1 byte/cycle with dataOut_ready held high.
- Widths: remaining is 16 bits; L-2 is computed in 16 bits and is never negative in the paths used.
- Packets are strictly back-to-back. The first byte after a packet ends is always treated as a length high byte.

Optional Feature:
- Macro: WORD_PACKER_STATS_EN.
- Defined: adds outputs pktCount[15:0] and dropCount[15:0], both reset to 0 and saturating at 0xFFFF.
  - pktCount increments on the cycle the last word of a packet is accepted downstream.
  - dropCount increments when lenError pulses.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- L=9 packet, bytes 00 09 00 03 00 00 00 05 AB, ready high:
  - Response: words 0x00090003, 0x00000005, 0xAB000000; last=1 only on the third word; lenError never asserts.
- L=12 packet, bytes 00 0C 00 01 00 00 00 07 11 22 33 44:
  - Response: exactly 3 words; the third is 0x11223344 with last=1; the next byte is framed as a new length.
- Back-pressure during an L=45 packet, dataOut_ready low for 6 cycles mid-packet:
  - The held word does not change while stalled.
  - byteIn_ready drops while dataOut_val is high and ready is low.
  - All 12 words arrive in order with last on word 12, whose value has lanes [23:0] zeroed.
- Length 0x0064 followed by a valid L=9 packet:
  - lenError pulses once; 98 bytes are consumed with no output.
  - The following packet is framed correctly.
  - With WORD_PACKER_STATS_EN: dropCount=1, pktCount=1.
- Length 0x0001, then an L=9 packet:
  - lenError pulses; the state returns straight to LEN_HI with no DROP.
  - The L=9 packet is framed correctly.
- reset_b pulsed low after 5 bytes of a packet, with a word held:
  - dataOut_val=0 and lenError=0 on the next cycle.
  - A subsequent L=9 packet produces exactly 3 correct words.
